// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and counter helper for the branch predictor
package bp_pkg;
    localparam int MODE_TAKEN     = 0;
    localparam int MODE_NOT_TAKEN = 1;
    localparam int MODE_BIMODAL   = 2;
    localparam int CNT_MAX_BITS   = 8;

    // Counters narrower than CNT_MAX_BITS travel in the low bits; cnt_max bounds the climb.
    function automatic logic [CNT_MAX_BITS-1:0] sat_update(
        input logic [CNT_MAX_BITS-1:0] cnt,
        input logic                    taken,
        input logic [CNT_MAX_BITS-1:0] cnt_max
    );
        logic [CNT_MAX_BITS-1:0] nxt;
        nxt = cnt;
        if (taken && (cnt != cnt_max)) begin
            nxt = cnt + 8'd1;
        end else if (!taken && (cnt != '0)) begin
            nxt = cnt - 8'd1;
        end
        return nxt;
    endfunction
endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - saturating counter table, async read, sync write
module bp_counter_table #(
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int RESET_CNT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CNT_BITS-1:0] rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [CNT_BITS-1:0] wr_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [CNT_BITS-1:0] mem_q [ENTRIES];
    logic [CNT_BITS-1:0] mem_d [ENTRIES];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= CNT_BITS'(RESET_CNT);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_cnt = mem_q[rd_idx];
endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - IF-stage branch prediction with ID-stage resolve
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int MODE      = MODE_BIMODAL,
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int RESET_CNT = 1,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_IF,
    input  logic [31:0]          pc_IF,
    input  logic [31:0]          PC_add_4,
    input  logic [31:0]          PC_add_imm,
    input  logic                 branch_ID,
    input  logic                 jump_or_not,
    output logic [31:0]          PC_out,
    output logic                 predict_jump,
    output logic                 correct,
    output logic [STAT_BITS-1:0] branch_cnt,
    output logic [STAT_BITS-1:0] mispred_cnt
);
    logic                 pend_valid_q, pend_valid_d;
    logic                 pred_q, pred_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [31:0]          add4_q, add4_d;
    logic [31:0]          imm_q, imm_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [STAT_BITS-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0]  idx_if;
    logic [CNT_BITS-1:0]  rd_cnt, wr_cnt;
    logic                 tbl_we, lookup, resolve, mispredict, pred_if;
    logic                 unused_pc_bits;

    assign idx_if         = pc_IF[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pc_IF[31:IDX_BITS+2], pc_IF[1:0]};
    assign lookup         = branch_IF & ~stall;
    assign resolve        = branch_ID & ~stall & pend_valid_q;
    assign mispredict     = resolve & (pred_q != jump_or_not);
    assign tbl_we         = resolve & (MODE == MODE_BIMODAL);
    assign wr_cnt         = CNT_BITS'(sat_update(CNT_MAX_BITS'(cnt_q), jump_or_not,
                                                 CNT_MAX_BITS'((1 << CNT_BITS) - 1)));

    bp_counter_table #(
        .IDX_BITS  (IDX_BITS),
        .CNT_BITS  (CNT_BITS),
        .RESET_CNT (RESET_CNT)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (idx_if),
        .rd_cnt (rd_cnt),
        .wr_en  (tbl_we),
        .wr_idx (idx_q),
        .wr_cnt (wr_cnt)
    );

    always_comb begin
        pred_if = 1'b0;
        if (MODE == MODE_TAKEN) begin
            pred_if = 1'b1;
        end else if (MODE == MODE_BIMODAL) begin
            pred_if = rd_cnt[CNT_BITS-1];
        end
    end

    always_comb begin
        correct      = ~mispredict;
        predict_jump = 1'b0;
        PC_out       = PC_add_4;
        if (mispredict) begin
            PC_out = jump_or_not ? imm_q : add4_q;
        end else if (lookup) begin
            predict_jump = pred_if;
            PC_out       = pred_if ? PC_add_imm : PC_add_4;
        end
    end

    // The prediction sees the pre-update counter, but the pending copy takes the
    // freshly written value so the next resolve steps from the right base.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pred_d        = pred_q;
        idx_d         = idx_q;
        add4_d        = add4_q;
        imm_d         = imm_q;
        cnt_d         = cnt_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!stall) begin
            pend_valid_d = lookup & ~mispredict;
            if (lookup && !mispredict) begin
                pred_d = pred_if;
                idx_d  = idx_if;
                add4_d = PC_add_4;
                imm_d  = PC_add_imm;
                cnt_d  = (tbl_we && (idx_q == idx_if)) ? wr_cnt : rd_cnt;
            end
            if (resolve && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
            end
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pred_q        <= 1'b0;
            idx_q         <= '0;
            add4_q        <= '0;
            imm_q         <= '0;
            cnt_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pred_q        <= pred_d;
            idx_q         <= idx_d;
            add4_q        <= add4_d;
            imm_q         <= imm_d;
            cnt_q         <= cnt_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for branch_predictor_bht
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch_IF = 1'b0, branch_ID = 1'b0, jump_or_not = 1'b0;
    logic [31:0] pc_IF = '0, PC_add_4 = 32'h4, PC_add_imm = '0;

    logic [31:0] pc0, pc2, pcs;
    logic        pj0, pj2, pjs, c0, c2, cs;
    logic [15:0] bc0, mc0, bc2, mc2;
    logic [1:0]  bcs, mcs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(.MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_IF(branch_IF), .pc_IF(pc_IF),
        .PC_add_4(PC_add_4), .PC_add_imm(PC_add_imm), .branch_ID(branch_ID),
        .jump_or_not(jump_or_not), .PC_out(pc0), .predict_jump(pj0), .correct(c0),
        .branch_cnt(bc0), .mispred_cnt(mc0));

    branch_predictor_bht #(.MODE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_IF(branch_IF), .pc_IF(pc_IF),
        .PC_add_4(PC_add_4), .PC_add_imm(PC_add_imm), .branch_ID(branch_ID),
        .jump_or_not(jump_or_not), .PC_out(pc2), .predict_jump(pj2), .correct(c2),
        .branch_cnt(bc2), .mispred_cnt(mc2));

    branch_predictor_bht #(.MODE(2), .STAT_BITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_IF(branch_IF), .pc_IF(pc_IF),
        .PC_add_4(PC_add_4), .PC_add_imm(PC_add_imm), .branch_ID(branch_ID),
        .jump_or_not(jump_or_not), .PC_out(pcs), .predict_jump(pjs), .correct(cs),
        .branch_cnt(bcs), .mispred_cnt(mcs));

    // Reference model state, one slot per instance: 0 = static taken, 1 = bimodal, 2 = bimodal/2-bit stats
    int          m_tbl [3][16];
    bit          m_pv [3], m_pred [3];
    int          m_idx [3];
    logic [31:0] m_a4 [3], m_imm [3];
    int          m_bc [3], m_mc [3];
    int          m_mode [3] = '{0, 2, 2};
    int          m_max [3]  = '{65535, 65535, 3};

    typedef struct {
        int          inst;
        logic [65:0] v;
        string       tag;
    } exp_t;
    exp_t sb [$];

    function automatic logic [65:0] obs(input int k);
        case (k)
            0:       return {pc0, pj0, c0, bc0, mc0};
            1:       return {pc2, pj2, c2, bc2, mc2};
            default: return {pcs, pjs, cs, 14'd0, bcs, 14'd0, mcs};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (obs(e.inst) !== e.v) begin
                bad++;
                $display("FAIL %s inst%0d {pc,pj,ok,bc,mc} got=%h want=%h", e.tag, e.inst, obs(e.inst), e.v);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) m_tbl[k][i] = 1;
            m_pv[k] = 0; m_pred[k] = 0; m_idx[k] = 0; m_a4[k] = '0; m_imm[k] = '0;
            m_bc[k] = 0; m_mc[k] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; branch_IF = 1'b0; branch_ID = 1'b0; stall = 1'b0; jump_or_not = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one cycle, pushes expected outputs, advances the model, returns at the negedge.
    task automatic step(input string tag, input bit bif, input logic [31:0] pc,
                        input logic [31:0] imm, input bit bid, input bit jon, input bit stl);
        @(posedge clk); #1;
        branch_IF = bif; pc_IF = pc; PC_add_4 = pc + 32'd4; PC_add_imm = imm;
        branch_ID = bid; jump_or_not = jon; stall = stl;
        for (int k = 0; k < 3; k++) begin
            bit          res, mis, lk, lp, pj;
            logic [31:0] po;
            int          ix;
            exp_t        e;
            ix  = int'(pc[5:2]);
            res = bid && !stl && m_pv[k];
            mis = res && (m_pred[k] != jon);
            lk  = bif && !stl;
            lp  = (m_mode[k] == 0) ? 1'b1 : (m_mode[k] == 1) ? 1'b0 : (m_tbl[k][ix] >= 2);
            pj  = 1'b0;
            po  = pc + 32'd4;
            if (mis) po = jon ? m_imm[k] : m_a4[k];
            else if (lk) begin pj = lp; po = lp ? imm : pc + 32'd4; end
            e.inst = k; e.tag = tag;
            e.v = {po, pj, !mis, 16'(m_bc[k]), 16'(m_mc[k])};
            sb.push_back(e);
            if (!stl) begin
                if (res) begin
                    if (m_bc[k] < m_max[k]) m_bc[k]++;
                    if (mis && m_mc[k] < m_max[k]) m_mc[k]++;
                    if (m_mode[k] == 2) begin
                        if (jon && m_tbl[k][m_idx[k]] < 3) m_tbl[k][m_idx[k]]++;
                        if (!jon && m_tbl[k][m_idx[k]] > 0) m_tbl[k][m_idx[k]]--;
                    end
                end
                m_pv[k] = lk && !mis;
                if (lk && !mis) begin
                    m_pred[k] = lp; m_idx[k] = ix; m_a4[k] = pc + 32'd4; m_imm[k] = imm;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        step("rst_idle", 0, 32'h100, 32'h300, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dut2.u_table.mem_q[i] !== 2'd1) begin
                bad++; $display("FAIL rst_cnt[%0d] got=%0d want=1", i, dut2.u_table.mem_q[i]);
            end
        end
        step("rst_orphan_id", 0, 32'h104, 32'h300, 1, 1, 0);
        total++;
        if (c2 !== 1'b1 || pc2 !== 32'h108) begin
            bad++; $display("FAIL rst_orphan got ok=%b pc=%h want ok=1 pc=00000108", c2, pc2);
        end
        step("rst_after", 0, 32'h108, 32'h300, 0, 0, 0);
        total++;
        if (bc2 !== 16'd0) begin bad++; $display("FAIL rst_stats got=%0d want=0", bc2); end
    endtask

    task automatic test_static_taken();
        do_reset();
        step("t1_lookup", 1, 32'h10, 32'h40, 0, 0, 0);
        total++;
        if (pc0 !== 32'h40 || pj0 !== 1'b1) begin
            bad++; $display("FAIL t1_lookup got pc=%h pj=%b want pc=00000040 pj=1", pc0, pj0);
        end
        step("t1_resolve", 0, 32'h14, 32'h99, 1, 0, 0);
        total++;
        if (c0 !== 1'b0 || pc0 !== 32'h14) begin
            bad++; $display("FAIL t1_resolve got ok=%b pc=%h want ok=0 pc=00000014", c0, pc0);
        end
        step("t1_after", 0, 32'h18, 32'h99, 0, 0, 0);
        total++;
        if (mc0 !== 16'd1 || bc0 !== 16'd1) begin
            bad++; $display("FAIL t1_stats got mc=%0d bc=%0d want mc=1 bc=1", mc0, bc0);
        end
    endtask

    task automatic test_bimodal_sat();
        int exp_p [3] = '{0, 1, 1};
        int exp_c [3] = '{2, 3, 3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step("t2_lookup", 1, 32'h10, 32'h80, 0, 0, 0);
            total++;
            if (pj2 !== 1'(exp_p[i])) begin
                bad++; $display("FAIL t2_pred[%0d] got=%b want=%0d", i, pj2, exp_p[i]);
            end
            if (i > 0) begin
                total++;
                if (dut2.u_table.mem_q[4] !== 2'(exp_c[i-1])) begin
                    bad++; $display("FAIL t2_cnt[%0d] got=%0d want=%0d", i - 1, dut2.u_table.mem_q[4], exp_c[i-1]);
                end
            end
            step("t2_resolve", 0, 32'h14, 32'h0, 1, 1, 0);
        end
        step("t2_after", 0, 32'h18, 32'h0, 0, 0, 0);
        total++;
        if (dut2.u_table.mem_q[4] !== 2'd3 || mc2 !== 16'd1 || bc2 !== 16'd3) begin
            bad++; $display("FAIL t2_final got cnt=%0d mc=%0d bc=%0d want cnt=3 mc=1 bc=3",
                            dut2.u_table.mem_q[4], mc2, bc2);
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs_t [4] = '{32'h10, 32'h50, 32'h10, 32'h50};
        int          exp_c [4] = '{2, 1, 2, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("t3_lookup", 1, pcs_t[i], pcs_t[i] + 32'h100, 0, 0, 0);
            step("t3_resolve", 0, pcs_t[i] + 32'd4, 32'h0, 1, (i % 2 == 0), 0);
            step("t3_gap", 0, 32'h200, 32'h0, 0, 0, 0);
            total++;
            if (dut2.u_table.mem_q[4] !== 2'(exp_c[i])) begin
                bad++; $display("FAIL t3_cnt[%0d] got=%0d want=%0d", i, dut2.u_table.mem_q[4], exp_c[i]);
            end
        end
        step("t3_b2b_lookup", 1, 32'h10, 32'h110, 0, 0, 0);
        step("t3_b2b_both", 1, 32'h50, 32'h150, 1, 0, 0);
        total++;
        if (c2 !== 1'b1 || pj2 !== 1'b0) begin
            bad++; $display("FAIL t3_b2b got ok=%b pj=%b want ok=1 pj=0", c2, pj2);
        end
        step("t3_b2b_resolve", 0, 32'h54, 32'h0, 1, 1, 0);
        step("t3_b2b_after", 0, 32'h58, 32'h0, 0, 0, 0);
        total++;
        if (dut2.u_table.mem_q[4] !== 2'd1) begin
            bad++; $display("FAIL t3_b2b_cnt got=%0d want=1", dut2.u_table.mem_q[4]);
        end
    endtask

    task automatic test_flush_with_if();
        do_reset();
        step("t4_lookup", 1, 32'h10, 32'h200, 0, 0, 0);
        step("t4_flush", 1, 32'h80, 32'h900, 1, 1, 0);
        total++;
        if (c2 !== 1'b0 || pc2 !== 32'h200 || pj2 !== 1'b0) begin
            bad++; $display("FAIL t4_flush got ok=%b pc=%h pj=%b want ok=0 pc=00000200 pj=0", c2, pc2, pj2);
        end
        step("t4_wrongpath_id", 0, 32'h84, 32'h0, 1, 1, 0);
        total++;
        if (c2 !== 1'b1) begin bad++; $display("FAIL t4_orphan got ok=%b want ok=1", c2); end
        step("t4_after", 0, 32'h88, 32'h0, 0, 0, 0);
        total++;
        if (bc2 !== 16'd1 || mc2 !== 16'd1) begin
            bad++; $display("FAIL t4_stats got bc=%0d mc=%0d want bc=1 mc=1", bc2, mc2);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step("t5_lookup", 1, 32'h10, 32'h400, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("t5_stall", 1, 32'h60, 32'h500, 1, 1, 1);
            total++;
            if (c2 !== 1'b1 || pj2 !== 1'b0 || pc2 !== 32'h64 || bc2 !== 16'd0 ||
                dut2.u_table.mem_q[4] !== 2'd1) begin
                bad++; $display("FAIL t5_stall[%0d] got ok=%b pj=%b pc=%h bc=%0d cnt=%0d want ok=1 pj=0 pc=00000064 bc=0 cnt=1",
                                i, c2, pj2, pc2, bc2, dut2.u_table.mem_q[4]);
            end
        end
        step("t5_release", 0, 32'h14, 32'h0, 1, 1, 0);
        total++;
        if (c2 !== 1'b0 || pc2 !== 32'h400) begin
            bad++; $display("FAIL t5_release got ok=%b pc=%h want ok=0 pc=00000400", c2, pc2);
        end
        step("t5_after", 0, 32'h18, 32'h0, 0, 0, 0);
        total++;
        if (dut2.u_table.mem_q[4] !== 2'd2 || mc2 !== 16'd1 || bc2 !== 16'd1) begin
            bad++; $display("FAIL t5_after got cnt=%0d mc=%0d bc=%0d want cnt=2 mc=1 bc=1",
                            dut2.u_table.mem_q[4], mc2, bc2);
        end
    endtask

    task automatic test_stat_sat_and_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step("t6_lookup", 1, 32'h20, 32'h700, 0, 0, 0);
            step("t6_resolve", 0, 32'h24, 32'h0, 1, (i % 2 == 0), 0);
        end
        step("t6_after", 0, 32'h28, 32'h0, 0, 0, 0);
        total++;
        if (mcs !== 2'd3 || bcs !== 2'd3 || mc2 !== 16'd5) begin
            bad++; $display("FAIL t6_sat got mcs=%0d bcs=%0d mc=%0d want mcs=3 bcs=3 mc=5", mcs, bcs, mc2);
        end
        step("t6_pending", 1, 32'h20, 32'h700, 0, 0, 0);
        do_reset();
        step("t6_post_reset", 0, 32'h24, 32'h0, 1, 0, 0);
        total++;
        if (cs !== 1'b1 || bcs !== 2'd0 || mcs !== 2'd0 || mc2 !== 16'd0 ||
            dut_s.u_table.mem_q[8] !== 2'd1 || dut2.u_table.mem_q[8] !== 2'd1) begin
            bad++; $display("FAIL t6_reset got ok=%b bcs=%0d mcs=%0d mc=%0d cnt_s=%0d cnt2=%0d want 1 0 0 0 1 1",
                            cs, bcs, mcs, mc2, dut_s.u_table.mem_q[8], dut2.u_table.mem_q[8]);
        end
        step("t6_after_reset", 0, 32'h28, 32'h0, 0, 0, 0);
        total++;
        if (bcs !== 2'd0 || bc2 !== 16'd0) begin
            bad++; $display("FAIL t6_no_stat got bcs=%0d bc=%0d want 0 0", bcs, bc2);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_static_taken();
        test_bimodal_sat();
        test_alias();
        test_flush_with_if();
        test_stall();
        test_stat_sat_and_reset();
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
